sync_memory: RTL and testbench

- Parametrised, clocked successor to the team's combinational byte memory; single-port synchronous RAM with a chip_en/read_write command interface.
- Adds a ready/valid handshake, per-byte write enables, and a configurable registered read latency.
- A post-reset clear engine zeroes every location; out-of-range accesses are trapped and flagged.
- Sits between bus-side command logic and local storage.

---
 rtl/sync_memory.sv | 145 ++++++++++++++
 tb/tb_sync_memory.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_memory.sv
// sync_memory: single-port synchronous RAM with a chip_en/read_write command
// interface, per-byte write enables, a post-reset clear engine, out-of-range
// trapping and a registered read path of 1 or 2 cycles.
//
// Handshake: a request (chip_en, read_write, address, data_in, byte_en) is
// accepted on a rising clk edge when chip_en=1 and ready=1; one request per
// cycle with no bubbles. Requests presented while ready=0 are dropped, not
// held. Reads answer with a one-cycle data_valid pulse RD_LAT cycles after
// accept; there is no back-pressure on the response side.
module sync_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_en,
  input  logic                  read_write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic                  ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter/compare constants are ADDR_W+1 bits so DEPTH = 2**ADDR_W fits.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_V  = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  // FSM state is kept as a plain named signal so checkers can bind to it.
  logic [0:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  cnt_idx;

  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;
  logic              wr_err;
  logic              out_err;

  assign ready    = (state == S_IDLE);
  assign busy     = (state == S_CLEAR);
  assign accept   = ready & chip_en;
  assign in_range = ({1'b0, address} < DEPTH_V);
  assign addr_idx = address[IDX_W-1:0];
  assign cnt_idx  = cnt[IDX_W-1:0];

  // Clear sequencer: walk cnt from 0 to DEPTH-1, then park in IDLE until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else if (state == S_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_V) begin
        state <= S_IDLE;
      end
    end
  end

  // Storage: zeroed by the clear engine, otherwise byte-masked in-range writes.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt_idx] <= '0;
    end else if (accept && read_write && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem[addr_idx][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // First read stage: sample the array at the accept edge; data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept & ~read_write;
      s1_err   <= accept & ~read_write & ~in_range;
      if (accept && !read_write) begin
        s1_data <= in_range ? mem[addr_idx] : '0;
      end
    end
  end

  // Out-of-range write flag: one cycle after accept regardless of RD_LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= accept & read_write & ~in_range;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid;
      logic              s2_err;
      logic [DATA_W-1:0] s2_data;

      // Optional output pipeline register; data only moves with a valid beat.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign data_valid = s2_valid;
      assign data_out   = s2_data;
      assign out_err    = s2_err;
    end else begin : g_lat1
      assign data_valid = s1_valid;
      assign data_out   = s1_data;
      assign out_err    = s1_err;
    end
  endgenerate

  assign addr_err = wr_err | out_err;

endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: directed checks of two sync_memory configurations sharing
// clock and reset: u0 (8-bit, DEPTH 256, RD_LAT 1) and u1 (32-bit,
// DEPTH 200, RD_LAT 2).
module tb_sync_memory;

  logic        clk;
  logic        rst;

  logic        ce0, rw0;
  logic [7:0]  a0, di0, do0;
  logic [0:0]  be0;
  logic        rdy0, dv0, err0, busy0;

  logic        ce1, rw1;
  logic [7:0]  a1;
  logic [31:0] di1, do1;
  logic [3:0]  be1;
  logic        rdy1, dv1, err1, busy1;

  int checks = 0;
  int errors = 0;
  int c0, c1, spur;

  sync_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .chip_en(ce0), .read_write(rw0), .address(a0),
    .data_in(di0), .byte_en(be0), .ready(rdy0), .data_out(do0),
    .data_valid(dv0), .addr_err(err0), .busy(busy0)
  );

  sync_memory #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .chip_en(ce1), .read_write(rw1), .address(a1),
    .data_in(di1), .byte_en(be1), .ready(rdy1), .data_out(do1),
    .data_valid(dv1), .addr_err(err1), .busy(busy1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until both blocks leave CLEAR, with reads held on chip_en;
  // each request is withdrawn as soon as its block reports ready.
  task automatic clear_count(output int n0, output int n1, output int bad);
    int n;
    n = 0; n0 = 0; n1 = 0; bad = 0;
    ce0 = 1'b1; rw0 = 1'b0; a0 = 8'd0;
    ce1 = 1'b1; rw1 = 1'b0; a1 = 8'd0;
    while ((busy0 || busy1) && n < 1000) begin
      tick();
      n++;
      if (dv0 || dv1 || err0 || err1) bad++;
      if (!busy0 && n0 == 0) begin n0 = n; ce0 = 1'b0; end
      if (!busy1 && n1 == 0) begin n1 = n; ce1 = 1'b0; end
    end
    ce0 = 1'b0;
    ce1 = 1'b0;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [7:0] d, input logic [0:0] be);
    ce0 = 1'b1; rw0 = 1'b1; a0 = a; di0 = d; be0 = be;
    tick();
    ce0 = 1'b0;
  endtask

  task automatic rd0(input logic [7:0] a, input logic [7:0] exp, input string tag);
    ce0 = 1'b1; rw0 = 1'b0; a0 = a;
    tick();
    ce0 = 1'b0;
    check({tag, "_dv"}, dv0, 1'b1);
    check({tag, "_data"}, do0, exp);
  endtask

  task automatic wr1(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    ce1 = 1'b1; rw1 = 1'b1; a1 = a; di1 = d; be1 = be;
    tick();
    ce1 = 1'b0;
  endtask

  task automatic rd1(input logic [7:0] a, input logic [31:0] exp, input logic experr,
                     input string tag);
    ce1 = 1'b1; rw1 = 1'b0; a1 = a;
    tick();
    ce1 = 1'b0;
    check({tag, "_dv_early"}, dv1, 1'b0);
    tick();
    check({tag, "_dv"}, dv1, 1'b1);
    check({tag, "_data"}, do1, exp);
    check({tag, "_err"}, err1, experr);
  endtask

  initial begin
    rst = 1'b1;
    ce0 = 0; rw0 = 0; a0 = 0; di0 = 0; be0 = 0;
    ce1 = 0; rw1 = 0; a1 = 0; di1 = 0; be1 = 0;
    repeat (3) tick();

    // Reset state
    check("rst_ready0", rdy0, 1'b0);
    check("rst_busy0", busy0, 1'b1);
    check("rst_dv0", dv0, 1'b0);
    check("rst_err0", err0, 1'b0);
    check("rst_do0", do0, 8'h00);
    check("rst_busy1", busy1, 1'b1);
    check("rst_do1", do1, 32'h0);

    // Clear length after reset release
    rst = 1'b0;
    clear_count(c0, c1, spur);
    check("clear_len0", c0, 256);
    check("clear_len1", c1, 200);
    check("clear_spurious", spur, 0);
    check("ready0", rdy0, 1'b1);
    check("ready1", rdy1, 1'b1);

    // Cleared contents
    rd0(8'd0, 8'h00, "clr0_a0");
    rd0(8'd128, 8'h00, "clr0_a128");
    rd0(8'd255, 8'h00, "clr0_a255");
    rd1(8'd199, 32'h0, 1'b0, "clr1_a199");

    // Read after write, u0 (RD_LAT 1)
    wr0(8'h10, 8'hA5, 1'b1);
    check("wr0_no_dv", dv0, 1'b0);
    rd0(8'h10, 8'hA5, "raw0");
    // byte_en=0 leaves the word alone
    wr0(8'h10, 8'h3C, 1'b0);
    rd0(8'h10, 8'hA5, "be0_zero");

    // Back-to-back reads of 1..4
    for (int i = 1; i <= 4; i++) wr0(8'(i), 8'(i), 1'b1);
    ce0 = 1'b1; rw0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a0 = 8'(i);
      tick();
      check("b2b_dv", dv0, 1'b1);
      check("b2b_data", do0, 32'(i));
    end
    ce0 = 1'b0;
    tick();
    check("b2b_dv_end", dv0, 1'b0);
    check("hold_data", do0, 8'h04);

    // Read after write and byte merge, u1 (RD_LAT 2)
    wr1(8'h20, 32'h000000A5, 4'b0001);
    rd1(8'h20, 32'h000000A5, 1'b0, "raw1");
    wr1(8'h10, 32'h11223344, 4'b1111);
    wr1(8'h10, 32'hAABBCCDD, 4'b0101);
    rd1(8'h10, 32'h11BB33DD, 1'b0, "merge1");

    // Out-of-range write: flag one cycle after accept, array unchanged
    wr1(8'd220, 32'hDEADBEEF, 4'b1111);
    check("oor_wr_err", err1, 1'b1);
    check("oor_wr_dv", dv1, 1'b0);
    tick();
    check("oor_wr_err_end", err1, 1'b0);
    rd1(8'd20, 32'h0, 1'b0, "oor_wr_alias");
    rd1(8'h10, 32'h11BB33DD, 1'b0, "oor_wr_keep");
    // Out-of-range read: zero data, err aligned with data_valid
    rd1(8'd220, 32'h0, 1'b1, "oor_rd");
    rd1(8'd199, 32'h0, 1'b0, "last_in_range");

    // Reset with reads in flight on both blocks
    ce0 = 1'b1; rw0 = 1'b0; a0 = 8'h10;
    ce1 = 1'b1; rw1 = 1'b0; a1 = 8'h10;
    tick();
    ce0 = 1'b0; ce1 = 1'b0;
    check("inflight_dv0_pre", dv0, 1'b1);
    rst = 1'b1;
    #1;
    check("inflight_dv0", dv0, 1'b0);
    check("inflight_do0", do0, 8'h00);
    check("inflight_busy0", busy0, 1'b1);
    check("inflight_ready0", rdy0, 1'b0);
    tick();
    check("inflight_dv1_a", dv1, 1'b0);
    tick();
    check("inflight_dv1_b", dv1, 1'b0);

    // Reset again mid-clear at cycle 100
    rst = 1'b0;
    repeat (100) tick();
    check("midclr_busy0", busy0, 1'b1);
    rst = 1'b1;
    #1;
    check("midclr_rst_busy0", busy0, 1'b1);
    check("midclr_rst_ready1", rdy1, 1'b0);
    tick();
    rst = 1'b0;
    clear_count(c0, c1, spur);
    check("reclear_len0", c0, 256);
    check("reclear_len1", c1, 200);
    check("reclear_spurious", spur, 0);

    // Contents cleared again
    rd0(8'h10, 8'h00, "reclr0");
    rd1(8'h10, 32'h0, 1'b0, "reclr1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
